// File: rtl/pcs_scr_pkg.sv
// Shared constants and types for the 40G/100G PCS scrambler, g(x) = x^58 + x^39 + 1.
package pcs_scr_pkg;

  localparam int LFSR_WIDTH = 58;
  localparam int TAP_A      = 39;
  localparam int TAP_B      = 58;

  typedef logic [LFSR_WIDTH-1:0] lfsr_state_t;

  localparam lfsr_state_t DEFAULT_SEED = {LFSR_WIDTH{1'b1}};

  // Number of beats needed before the state holds only line-derived bits.
  function automatic int sync_beats(input int width);
    return (LFSR_WIDTH + width - 1) / width;
  endfunction

endpackage

// File: rtl/pcs_lfsr58_core.sv
// Combinational multi-bit step of the x^58+x^39+1 scrambler or descrambler.
// Every output bit and next-state bit is a fixed XOR over {state, data},
// so the per-bit masks are worked out at elaboration and the logic is
// one XOR-reduce per bit.
module pcs_lfsr58_core
  import pcs_scr_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int DESCRAMBLE = 0
) (
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic [LFSR_WIDTH-1:0] i_state,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LFSR_WIDTH-1:0] o_state
);

  // Input vector: data bits first, then state bits (state[k] at DATA_WIDTH+k).
  localparam int NIN = DATA_WIDTH + LFSR_WIDTH;

  // Mask selection: sel=0 -> payload output bit idx, sel=1 -> next-state bit idx.
  // hist holds the dependency mask of every line bit S_p, entry p+LFSR_WIDTH,
  // p running from -LFSR_WIDTH (oldest state bit) to DATA_WIDTH-1.
  function automatic logic [NIN-1:0] tap_mask(input bit sel, input int idx);
    logic [NIN*NIN-1:0] hist;
    logic [NIN-1:0]     m;
    hist = '0;
    for (int k = 1; k <= LFSR_WIDTH; k++) begin
      m = '0;
      m[DATA_WIDTH+k-1] = 1'b1;
      hist[(LFSR_WIDTH-k)*NIN +: NIN] = m;
    end
    for (int j = 0; j < DATA_WIDTH; j++) begin
      m = '0;
      m[j] = 1'b1;
      if (DESCRAMBLE == 0) begin
        m = m ^ hist[(j+LFSR_WIDTH-TAP_A)*NIN +: NIN]
              ^ hist[(j+LFSR_WIDTH-TAP_B)*NIN +: NIN];
      end
      hist[(j+LFSR_WIDTH)*NIN +: NIN] = m;
    end
    if (!sel) begin
      if (DESCRAMBLE == 0) begin
        m = hist[(idx+LFSR_WIDTH)*NIN +: NIN];
      end else begin
        m = '0;
        m[idx] = 1'b1;
        m = m ^ hist[(idx+LFSR_WIDTH-TAP_A)*NIN +: NIN]
              ^ hist[(idx+LFSR_WIDTH-TAP_B)*NIN +: NIN];
      end
    end else begin
      // Next state[k] is the line bit k+1 positions before the next beat.
      m = hist[(DATA_WIDTH-1-idx+LFSR_WIDTH)*NIN +: NIN];
    end
    return m;
  endfunction

  logic [NIN-1:0] w_x;
  assign w_x = {i_state, i_data};

  for (genvar gi = 0; gi < DATA_WIDTH; gi++) begin : g_data
    localparam logic [NIN-1:0] MASK = tap_mask(1'b0, gi);
    assign o_data[gi] = ^(w_x & MASK);
  end

  for (genvar gi = 0; gi < LFSR_WIDTH; gi++) begin : g_state
    localparam logic [NIN-1:0] MASK = tap_mask(1'b1, gi);
    assign o_state[gi] = ^(w_x & MASK);
  end

endmodule

// File: rtl/pcs_scrambler_pipe.sv
// Registered self-synchronising PCS scrambler/descrambler, one per lane.
// One output register with valid/ready; sync header rides alongside unscrambled.
module pcs_scrambler_pipe
  import pcs_scr_pkg::*;
#(
  parameter int                  DATA_WIDTH = 64,
  parameter int                  HDR_WIDTH  = 2,
  parameter int                  DESCRAMBLE = 0,
  parameter logic [LFSR_WIDTH-1:0] SEED     = DEFAULT_SEED
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [HDR_WIDTH-1:0]  in_hdr,
  input  logic                  bypass,
  input  logic                  seed_load,
  input  logic [LFSR_WIDTH-1:0] seed_value,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [HDR_WIDTH-1:0]  out_hdr,
  output logic                  synced,
  output logic [LFSR_WIDTH-1:0] lfsr_state
);

  localparam int NSYNC = sync_beats(DATA_WIDTH);
  localparam int CNT_W = $clog2(NSYNC + 1);
  localparam logic [CNT_W-1:0] NSYNC_C = CNT_W'(NSYNC);

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [HDR_WIDTH-1:0]  r_out_hdr;
  logic [LFSR_WIDTH-1:0] r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_synced;

  logic                  w_accept;
  logic                  w_advance;
  logic [DATA_WIDTH-1:0] w_core_data;
  logic [LFSR_WIDTH-1:0] w_core_state;
  logic [CNT_W-1:0]      w_cnt_inc;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_advance = w_accept && !bypass;
  assign w_cnt_inc = r_cnt + CNT_W'(1);

  pcs_lfsr58_core #(
    .DATA_WIDTH (DATA_WIDTH),
    .DESCRAMBLE (DESCRAMBLE)
  ) u_core (
    .i_data  (in_data),
    .i_state (r_state),
    .o_data  (w_core_data),
    .o_state (w_core_state)
  );

  // Output register: load on accept, drop valid once the beat has drained.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_hdr   <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bypass ? in_data : w_core_data;
      r_out_hdr   <= in_hdr;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // LFSR state: seed load overrides the update of a beat accepted in the same cycle.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_state <= SEED;
    end else if (seed_load) begin
      r_state <= seed_value;
    end else if (w_advance) begin
      r_state <= w_core_state;
    end
  end

  // Sync counter: saturating count of processed beats since reset/seed load.
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      r_cnt    <= '0;
      r_synced <= 1'b0;
    end else if (seed_load) begin
      r_cnt    <= '0;
      r_synced <= 1'b0;
    end else if (w_advance && (r_cnt != NSYNC_C)) begin
      r_cnt    <= w_cnt_inc;
      r_synced <= (w_cnt_inc == NSYNC_C);
    end
  end

  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_hdr    = r_out_hdr;
  assign synced     = r_synced;
  assign lfsr_state = r_state;

endmodule
